tx_fsm: RTL and testbench

- Control FSM for the UART transmitter.
- Sequences a continuous frame: start bit, DATA_BITS data bits (LSB first), parity bit, stop bit.
- Drives the TX-line output mux select and the strobes for the datapath shift register and parity register.
- Has no handshake inputs. After reset it free-runs, emitting back-to-back frames; the datapath supplies the data word.

---
 rtl/tx_fsm_pkg.sv | 23 ++
 rtl/tx_bit_counter.sv | 29 ++
 rtl/tx_fsm.sv | 84 ++++++++
 tb/tb_tx_fsm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/tx_fsm_pkg.sv
// Shared types and constants for the UART transmit control FSM.
// Optional parity state is selected by the TX_FSM_PARITY_EN macro.
package tx_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  // Bit counter needs at least one bit even for degenerate widths.
  function automatic int cnt_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Data-bit counter for the TX FSM: synchronous clear, count enable and a
// flag raised while the counter sits on the last data bit.
module tx_bit_counter
  import tx_fsm_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CNT_W = cnt_width(DATA_BITS);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(DATA_BITS - 1));

endmodule

// File: rtl/tx_fsm.sv
// UART transmit control FSM: free-running back-to-back frames with Moore
// strobes for the datapath. Define TX_FSM_PARITY_EN to include the parity bit.
module tx_fsm
  import tx_fsm_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] sel,
  output logic       load,
  output logic       shift,
  output logic       parity_load
);

  state_t state;
  logic   last;
  logic   cnt_clear;
  logic   cnt_en;

  // Counter only advances inside DATA and is parked at zero everywhere else.
  assign cnt_en    = (state == DATA);
  assign cnt_clear = (state != DATA) || last;

  tx_bit_counter #(
    .DATA_BITS(DATA_BITS)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_en),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  state <= START;
        START: state <= DATA;
        DATA: begin
          if (last) begin
`ifdef TX_FSM_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef TX_FSM_PARITY_EN
        PARITY: state <= STOP;
`endif
        STOP:    state <= START;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sel         = SEL_STOP;
    load        = 1'b0;
    shift       = 1'b0;
    parity_load = 1'b0;
    case (state)
      START: begin
        sel  = SEL_START;
        load = 1'b1;
`ifdef TX_FSM_PARITY_EN
        parity_load = 1'b1;
`endif
      end
      DATA: begin
        sel   = SEL_DATA;
        shift = 1'b1;
      end
`ifdef TX_FSM_PARITY_EN
      PARITY: sel = SEL_PARITY;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_fsm.sv
// Directed scoreboard bench for tx_fsm; follows TX_FSM_PARITY_EN and the
// DATA_BITS parameter of the build.
module tb_tx_fsm;

  parameter int DATA_BITS = 8;

`ifdef TX_FSM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME   = DATA_BITS + (PAR_EN ? 3 : 2);
  localparam int PH_IDLE = -1;
  localparam int PH_PAR  = DATA_BITS + 1;
  localparam int PH_STOP = DATA_BITS + 2;

  typedef struct packed {
    logic [1:0] sel;
    logic       load;
    logic       shift;
    logic       pl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sel;
  logic       load;
  logic       shift;
  logic       parity_load;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   last_load = -1;
  int   loads_seen = 0;
  int   phase = PH_IDLE;
  exp_t sb[$];

  tx_fsm #(.DATA_BITS(DATA_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .load       (load),
    .shift      (shift),
    .parity_load(parity_load)
  );

  always #5 clk = ~clk;

  // Reference frame position: -1 idle, 0 start, 1..DATA_BITS data, then parity/stop.
  function automatic int next_phase(input int ph, input logic rst);
    if (rst) return PH_IDLE;
    if (ph == PH_IDLE) return 0;
    if (ph < DATA_BITS) return ph + 1;
    if (ph == DATA_BITS) return PAR_EN ? PH_PAR : PH_STOP;
    if (ph == PH_PAR) return PH_STOP;
    return 0;
  endfunction

  function automatic exp_t expect_of(input int ph);
    exp_t e;
    e = '{sel: 2'b11, load: 1'b0, shift: 1'b0, pl: 1'b0};
    if (ph == 0) begin
      e.sel = 2'b00; e.load = 1'b1; e.pl = PAR_EN;
    end else if (ph >= 1 && ph <= DATA_BITS) begin
      e.sel = 2'b01; e.shift = 1'b1;
    end else if (ph == PH_PAR) begin
      e.sel = 2'b10;
    end
    return e;
  endfunction

  task automatic step(input logic rst);
    exp_t e;
    reset = rst;
    phase = next_phase(phase, rst);
    sb.push_back(expect_of(phase));
    @(posedge clk);
    #1;
    cycle++;
    e = sb.pop_front();
    checks++;
    assert (sel === e.sel) else begin
      errors++; $error("FAIL sel cyc=%0d got=%b exp=%b", cycle, sel, e.sel);
    end
    checks++;
    assert (load === e.load) else begin
      errors++; $error("FAIL load cyc=%0d got=%b exp=%b", cycle, load, e.load);
    end
    checks++;
    assert (shift === e.shift) else begin
      errors++; $error("FAIL shift cyc=%0d got=%b exp=%b", cycle, shift, e.shift);
    end
    checks++;
    assert (parity_load === e.pl) else begin
      errors++; $error("FAIL parity_load cyc=%0d got=%b exp=%b", cycle, parity_load, e.pl);
    end
    if (rst) begin
      last_load = -1;
    end else if (load === 1'b1) begin
      loads_seen++;
      if (last_load >= 0) begin
        checks++;
        assert (cycle - last_load == FRAME) else begin
          errors++; $error("FAIL period cyc=%0d got=%0d exp=%0d", cycle, cycle - last_load, FRAME);
        end
      end
      last_load = cycle;
    end
  endtask

  initial begin
    reset = 1'b1;
    // Reset held two cycles, then released.
    step(1'b1);
    step(1'b1);
    step(1'b0);
    // Three back-to-back frames plus the next START.
    for (int i = 0; i < 3 * FRAME + 1; i++) step(1'b0);
    checks++;
    assert (loads_seen == 4) else begin
      errors++; $error("FAIL load_count got=%0d exp=%0d", loads_seen, 4);
    end
    // Run into DATA bit 4, then pulse reset for one cycle.
    while (phase != 5) step(1'b0);
    step(1'b1);
    step(1'b0);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0);
    // Long reset hold mid-frame.
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < FRAME + 2; i++) step(1'b0);
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL scoreboard_drain got=%0d exp=%0d", sb.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
